// File: rtl/fp_pkg.sv
// Shared FP definitions: field widths, rounding modes, exception flag indices and
// the int-to-float converter state encoding.
package fp_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    // Resolved RISC-V rounding modes; 5-7 fall back to RNE.
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } cvt_state_e;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision shared by the FP conversion and arithmetic units.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       s_i,
    output logic       inc_o
);

    // Decide whether the truncated mantissa is bumped by one ulp.
    always_comb begin
        inc_o = 1'b0;
        case (rm_i)
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = (g_i | s_i) & sign_i;
            RM_RUP:  inc_o = (g_i | s_i) & ~sign_i;
            RM_RMM:  inc_o = g_i;
            default: inc_o = g_i & (s_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/fp_int_to_float.sv
// FCVT.S.W / FCVT.S.WU: iterative one-bit-per-cycle normalisation followed by a
// single rounding cycle, behind valid/ready handshakes on both sides.
module fp_int_to_float
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    localparam logic [EXP_W-1:0] ExpInit = EXP_W'(BIAS + XLEN - 1);

    cvt_state_e        state_q, state_d;
    logic              sign_q, sign_d;
    logic [31:0]       mag_q, mag_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [2:0]        rm_q, rm_d;
    logic [31:0]       result_q, result_d;
    logic [4:0]        fflags_q, fflags_d;

    logic              in_sign;
    logic [31:0]       in_mag;
    logic              rnd_g, rnd_s, rnd_lsb, rnd_inc, rnd_carry;
    logic [MANT_W-1:0] rnd_sum;
    logic [MANT_W-1:0] mant_rnd;
    logic [EXP_W-1:0]  exp_rnd;

    // Operand sign/magnitude; 0x80000000 negates to itself, which is the right magnitude.
    always_comb begin
        in_sign = ~is_unsigned & int_in[31];
        in_mag  = in_sign ? (~int_in + 32'd1) : int_in;
    end

    // Guard/sticky/lsb taken from the normalised magnitude (bit 31 is the hidden one).
    always_comb begin
        rnd_g   = mag_q[7];
        rnd_s   = |mag_q[6:0];
        rnd_lsb = mag_q[8];
        {rnd_carry, rnd_sum} = {1'b0, mag_q[30:8]} + {{MANT_W{1'b0}}, rnd_inc};
        mant_rnd = rnd_carry ? '0 : rnd_sum;
        exp_rnd  = rnd_carry ? exp_q + 8'd1 : exp_q;
    end

    fp_round_inc u_round_inc (
        .rm_i   (rm_q),
        .sign_i (sign_q),
        .lsb_i  (rnd_lsb),
        .g_i    (rnd_g),
        .s_i    (rnd_s),
        .inc_o  (rnd_inc)
    );

    // Next-state and datapath updates for the conversion FSM.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        rm_d     = rm_q;
        result_d = result_q;
        fflags_d = fflags_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    mag_d  = in_mag;
                    exp_d  = ExpInit;
                    rm_d   = rm;
                    if (in_mag == 32'd0) begin
                        // Zero always converts to +0, exact.
                        result_d = '0;
                        fflags_d = '0;
                        state_d  = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (mag_q[31]) begin
                    state_d = StRound;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            StRound: begin
                // Exponent tops out at 159, so no overflow path is needed.
                result_d          = {sign_q, exp_rnd, mant_rnd};
                fflags_d          = '0;
                fflags_d[FLAG_NX] = rnd_g | rnd_s;
                state_d           = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            rm_q     <= RM_RNE;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    // Handshake outputs come straight from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = result_q;
        fflags    = fflags_q;
    end

endmodule
